mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit: decodes RISC-V memory ops, issues one request at a time on a
// shared memory port and returns exactly one writeback per accepted op.
module mem_access_unit #(
    parameter int XLEN    = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [9:0]      in_opcode,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_sdata,
    input  logic [RD_W-1:0] in_rd,
    output logic            busy,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_len,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_done,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [1:0]      wb_exc
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [1:0] EXC_NONE     = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;
    localparam bit IS64 = (XLEN == 64);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [2:0]        funct3_q;
    logic [RD_W-1:0]   rd_q;

    logic              is_load;
    logic              is_store;
    logic              legal;
    logic              aligned;
    logic [3:0]        len_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   ext_data;
    logic              complete;
    logic              timed_out;

    assign busy = (state == REQ) || (state == WAIT);

    // Decode of the incoming op, plus extension of the returning load data
    always_comb begin
        is_load  = (in_opcode[6:0] == OP_LOAD);
        is_store = (in_opcode[6:0] == OP_STORE);
        legal    = 1'b0;
        if (is_load) begin
            case (in_opcode[9:7])
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                3'b011, 3'b110:                         legal = IS64;
                default:                                legal = 1'b0;
            endcase
        end else if (is_store) begin
            legal = (in_opcode[9:7] <= 3'b010) || ((in_opcode[9:7] == 3'b011) && IS64);
        end

        case (in_opcode[8:7])
            2'b00: begin
                aligned = 1'b1;
                len_d   = 4'b0001;
                wdata_d = XLEN'(in_sdata[7:0]);
            end
            2'b01: begin
                aligned = ~in_addr[0];
                len_d   = 4'b0010;
                wdata_d = XLEN'(in_sdata[15:0]);
            end
            2'b10: begin
                aligned = (in_addr[1:0] == 2'b00);
                len_d   = 4'b0100;
                wdata_d = XLEN'(in_sdata[31:0]);
            end
            default: begin
                aligned = (in_addr[2:0] == 3'b000);
                len_d   = 4'b1000;
                wdata_d = in_sdata;
            end
        endcase

        case (funct3_q)
            3'b000:  ext_data = XLEN'($signed(mem_rdata[7:0]));
            3'b001:  ext_data = XLEN'($signed(mem_rdata[15:0]));
            3'b010:  ext_data = XLEN'($signed(mem_rdata[31:0]));
            3'b100:  ext_data = XLEN'(mem_rdata[7:0]);
            3'b101:  ext_data = XLEN'(mem_rdata[15:0]);
            3'b110:  ext_data = XLEN'(mem_rdata[31:0]);
            default: ext_data = mem_rdata;
        endcase

        complete  = mem_done && (((state == REQ) && mem_gnt) || (state == WAIT));
        timed_out = (TIMEOUT != 0) && (state == WAIT) && !mem_done && (wait_cnt == CNT_LAST);
    end

    // Transaction FSM; completion and timeout override the per-state defaults
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_len   <= 4'b0001;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_exc    <= EXC_NONE;
            wait_cnt  <= '0;
            rd_q      <= '0;
            funct3_q  <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    state <= IDLE;
                    if (in_valid) begin
                        if (!is_load && !is_store) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= in_rd;
                            wb_data  <= in_addr;
                            wb_exc   <= EXC_NONE;
                        end else if (!legal) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= '0;
                            wb_data  <= '0;
                            wb_exc   <= EXC_ILLEGAL;
                        end else if (!aligned) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= '0;
                            wb_data  <= in_addr;
                            wb_exc   <= EXC_MISALIGN;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_len   <= len_d;
                            mem_addr  <= in_addr;
                            mem_wdata <= is_store ? wdata_d : '0;
                            rd_q      <= in_rd;
                            funct3_q  <= in_opcode[9:7];
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if ((TIMEOUT != 0) && !mem_done) wait_cnt <= wait_cnt + 1'b1;
                end
            endcase

            if (complete) begin
                state    <= RESP;
                wb_valid <= 1'b1;
                wb_exc   <= EXC_NONE;
                wb_rd    <= mem_we ? '0 : rd_q;
                wb_data  <= mem_we ? '0 : ext_data;
            end else if (timed_out) begin
                state    <= RESP;
                wb_valid <= 1'b1;
                wb_exc   <= EXC_TIMEOUT;
                wb_rd    <= '0;
                wb_data  <= '0;
            end
        end
    end

endmodule
